// File: rtl/axil_strobe_bridge.sv
// AXI-Lite slave fanning single register accesses out to N_CHAN strobe/ack channels,
// with alternating read/write arbitration, per-access timeout (SLVERR) and DECERR decode.
module axil_strobe_bridge #(
    parameter int unsigned N_CHAN  = 4,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned LOC_W   = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   axilClk,
    input  logic                   axilRstN,
    input  logic [31:0]            s_araddr,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [31:0]            s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    input  logic [31:0]            s_awaddr,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [31:0]            s_wdata,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [1:0]             s_bresp,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    output logic [LOC_W-1:0]       ch_raddr,
    output logic [LOC_W-1:0]       ch_waddr,
    output logic [31:0]            ch_wdata,
    output logic [N_CHAN-1:0]      ch_rstr,
    output logic [N_CHAN-1:0]      ch_wstr,
    input  logic [N_CHAN-1:0]      ch_rack,
    input  logic [N_CHAN-1:0]      ch_wack,
    input  logic [N_CHAN*32-1:0]   ch_din
);

    localparam int unsigned N_SEL = 2 ** SEL_W;
    localparam int unsigned TW    = 16;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  RESP_DECERR  = 2'b11;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RADDR,
        S_WADDR,
        S_RSTR,
        S_WSTR,
        S_RRESP,
        S_WRESP
    } state_t;

    state_t            state, state_d;
    logic              prio_rd, prio_rd_d;
    logic [SEL_W-1:0]  sel, sel_d;
    logic [TW-1:0]     timer, timer_d;

    logic              arready_d, awready_d, wready_d, rvalid_d, bvalid_d;
    logic [31:0]       rdata_d, wdata_d;
    logic [1:0]        rresp_d, bresp_d;
    logic [LOC_W-1:0]  raddr_d, waddr_d;
    logic [N_CHAN-1:0] rstr_d, wstr_d;
    logic [N_SEL-1:0]  sel_oh;

    // Select decode is padded to the full select space so any sel indexes safely
    logic [SEL_W-1:0]  ar_sel, aw_sel;
    logic              ar_hit, aw_hit;
    logic [N_SEL-1:0]  rack_ext, wack_ext;
    logic [31:0]       din_arr [N_SEL];
    logic              unused_addr;

    assign ar_sel      = s_araddr[SEL_LSB +: SEL_W];
    assign aw_sel      = s_awaddr[SEL_LSB +: SEL_W];
    assign ar_hit      = 32'(ar_sel) < N_CHAN;
    assign aw_hit      = 32'(aw_sel) < N_CHAN;
    assign rack_ext    = N_SEL'(ch_rack);
    assign wack_ext    = N_SEL'(ch_wack);
    assign unused_addr = ^{s_araddr, s_awaddr};

    for (genvar k = 0; k < N_SEL; k++) begin : g_din
        if (k < N_CHAN) begin : g_map
            assign din_arr[k] = ch_din[32*k +: 32];
        end else begin : g_pad
            assign din_arr[k] = '0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        prio_rd_d = prio_rd;
        sel_d     = sel;
        timer_d   = timer;
        raddr_d   = ch_raddr;
        waddr_d   = ch_waddr;
        wdata_d   = ch_wdata;
        rdata_d   = s_rdata;
        rresp_d   = s_rresp;
        bresp_d   = s_bresp;
        sel_oh    = '0;

        case (state)
            S_IDLE: begin
                if (s_arvalid && (!(s_awvalid && s_wvalid) || prio_rd)) begin
                    state_d   = S_RADDR;
                    prio_rd_d = 1'b0;
                end else if (s_awvalid && s_wvalid) begin
                    state_d   = S_WADDR;
                    prio_rd_d = 1'b1;
                end
            end
            S_RADDR: begin
                sel_d   = ar_sel;
                raddr_d = s_araddr[LOC_W+1:2];
                timer_d = TW'(1);
                if (ar_hit) begin
                    state_d = S_RSTR;
                end else begin
                    state_d = S_RRESP;
                    rresp_d = RESP_DECERR;
                    rdata_d = '0;
                end
            end
            S_WADDR: begin
                sel_d   = aw_sel;
                waddr_d = s_awaddr[LOC_W+1:2];
                wdata_d = s_wdata;
                timer_d = TW'(1);
                if (aw_hit) begin
                    state_d = S_WSTR;
                end else begin
                    state_d = S_WRESP;
                    bresp_d = RESP_DECERR;
                end
            end
            S_RSTR: begin
                if (rack_ext[sel]) begin
                    state_d = S_RRESP;
                    rresp_d = RESP_OKAY;
                    rdata_d = din_arr[sel];
                end else if (timer == TW'(TIMEOUT)) begin
                    state_d = S_RRESP;
                    rresp_d = RESP_SLVERR;
                    rdata_d = TIMEOUT_DATA;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_WSTR: begin
                if (wack_ext[sel]) begin
                    state_d = S_WRESP;
                    bresp_d = RESP_OKAY;
                end else if (timer == TW'(TIMEOUT)) begin
                    state_d = S_WRESP;
                    bresp_d = RESP_SLVERR;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            S_RRESP: if (s_rready) state_d = S_IDLE;
            S_WRESP: if (s_bready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Handshake and strobe outputs are registered copies of the next state
        sel_oh    = N_SEL'(1) << sel_d;
        arready_d = (state_d == S_RADDR);
        awready_d = (state_d == S_WADDR);
        wready_d  = (state_d == S_WADDR);
        rvalid_d  = (state_d == S_RRESP);
        bvalid_d  = (state_d == S_WRESP);
        rstr_d    = (state_d == S_RSTR) ? sel_oh[N_CHAN-1:0] : '0;
        wstr_d    = (state_d == S_WSTR) ? sel_oh[N_CHAN-1:0] : '0;
    end

    always_ff @(posedge axilClk or negedge axilRstN) begin
        if (!axilRstN) begin
            state     <= S_IDLE;
            prio_rd   <= 1'b1;
            sel       <= '0;
            timer     <= '0;
            s_arready <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_rvalid  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= '0;
            s_bresp   <= '0;
            ch_raddr  <= '0;
            ch_waddr  <= '0;
            ch_wdata  <= '0;
            ch_rstr   <= '0;
            ch_wstr   <= '0;
        end else begin
            state     <= state_d;
            prio_rd   <= prio_rd_d;
            sel       <= sel_d;
            timer     <= timer_d;
            s_arready <= arready_d;
            s_awready <= awready_d;
            s_wready  <= wready_d;
            s_rvalid  <= rvalid_d;
            s_bvalid  <= bvalid_d;
            s_rdata   <= rdata_d;
            s_rresp   <= rresp_d;
            s_bresp   <= bresp_d;
            ch_raddr  <= raddr_d;
            ch_waddr  <= waddr_d;
            ch_wdata  <= wdata_d;
            ch_rstr   <= rstr_d;
            ch_wstr   <= wstr_d;
        end
    end

endmodule

// File: tb/tb_axil_strobe_bridge.sv
// Bench for axil_strobe_bridge: directed vector table, corner sequences (latency,
// reset, arbitration) and random single accesses against a rule-level model.
module tb_axil_strobe_bridge;

    localparam int N_CHAN  = 4;
    localparam int SEL_LSB = 12;
    localparam int SEL_W   = 3;
    localparam int LOC_W   = 10;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0]          s_araddr, s_awaddr, s_wdata, s_rdata;
    logic                 s_arvalid, s_arready, s_rvalid, s_rready;
    logic                 s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]           s_rresp, s_bresp;
    logic [LOC_W-1:0]     ch_raddr, ch_waddr;
    logic [31:0]          ch_wdata;
    logic [N_CHAN-1:0]    ch_rstr, ch_wstr, ch_rack, ch_wack;
    logic [N_CHAN*32-1:0] ch_din;

    axil_strobe_bridge #(
        .N_CHAN(N_CHAN), .SEL_LSB(SEL_LSB), .SEL_W(SEL_W), .LOC_W(LOC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .axilClk(clk), .axilRstN(rst_n),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .ch_raddr(ch_raddr), .ch_waddr(ch_waddr), .ch_wdata(ch_wdata),
        .ch_rstr(ch_rstr), .ch_wstr(ch_wstr), .ch_rack(ch_rack), .ch_wack(ch_wack),
        .ch_din(ch_din)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Channel responders: ack after ack_dly strobe cycles (0 = never); noise acks idle channels
    logic [31:0] din_val [N_CHAN];
    int ack_dly = 0;
    bit noise   = 1'b0;
    int rc [N_CHAN];
    int wc [N_CHAN];
    int rtot [N_CHAN];
    int wtot [N_CHAN];

    initial begin
        for (int k = 0; k < N_CHAN; k++) begin
            rc[k] = 0; wc[k] = 0; rtot[k] = 0; wtot[k] = 0;
            din_val[k] = 32'hA5A5_0000 + 32'(k);
        end
    end

    always_comb begin
        for (int k = 0; k < N_CHAN; k++) ch_din[32*k +: 32] = din_val[k];
    end

    always @(negedge clk) begin
        for (int k = 0; k < N_CHAN; k++) begin
            rc[k] = ch_rstr[k] ? rc[k] + 1 : 0;
            wc[k] = ch_wstr[k] ? wc[k] + 1 : 0;
            ch_rack[k] = ch_rstr[k] ? (ack_dly != 0 && rc[k] == ack_dly) : noise;
            ch_wack[k] = ch_wstr[k] ? (ack_dly != 0 && wc[k] == ack_dly) : noise;
            if (ch_rstr[k]) rtot[k] = rtot[k] + 1;
            if (ch_wstr[k]) wtot[k] = wtot[k] + 1;
        end
    end

    typedef struct {
        bit               wr;
        logic [31:0]      addr;
        logic [31:0]      data;
        int               dly;
        bit               noise;
        int               hold;
        logic [1:0]       resp;
        logic [31:0]      rdata;
        int               cyc;
        logic [LOC_W-1:0] loc;
    } vec_t;

    // Rule-level prediction of one isolated access
    function automatic vec_t model(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                   input int dly, input bit nz, input int hold);
        vec_t v;
        int   ch;
        v.wr = wr; v.addr = addr; v.data = data; v.dly = dly; v.noise = nz; v.hold = hold;
        ch    = int'((addr >> SEL_LSB) & 32'(2 ** SEL_W - 1));
        v.loc = LOC_W'((addr >> 2) & 32'(2 ** LOC_W - 1));
        if (ch >= N_CHAN) begin
            v.resp = 2'b11; v.rdata = 32'h0; v.cyc = 0;
        end else if (dly >= 1 && dly <= TIMEOUT) begin
            v.resp = 2'b00; v.rdata = din_val[ch]; v.cyc = dly;
        end else begin
            v.resp = 2'b10; v.rdata = 32'hDEAD_BEEF; v.cyc = TIMEOUT;
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int          rs [N_CHAN];
        int          ws [N_CHAN];
        int          ch, tot, on, wrong;
        bit          seen, stable;
        logic [31:0] d0;
        logic [1:0]  p0;
        ack_dly = v.dly;
        noise   = v.noise;
        ch      = int'(v.addr[SEL_LSB +: SEL_W]);
        for (int k = 0; k < N_CHAN; k++) begin rs[k] = rtot[k]; ws[k] = wtot[k]; end
        if (!v.wr) begin
            s_araddr = v.addr; s_arvalid = 1'b1; seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin @(posedge clk); #1; seen = s_arready; end
            chk({tag, " arready"}, 64'(seen), 64'(1));
            @(posedge clk); #1; s_arvalid = 1'b0;
            chk({tag, " arready_pulse"}, 64'(s_arready), 64'(0));
            seen = s_rvalid;
            for (int n = 0; n < TIMEOUT + 20 && !seen; n++) begin @(posedge clk); #1; seen = s_rvalid; end
            chk({tag, " rvalid"}, 64'(seen), 64'(1));
            d0 = s_rdata; p0 = s_rresp; stable = 1'b1;
            repeat (v.hold) begin
                @(posedge clk); #1;
                if (!s_rvalid || s_rdata !== d0 || s_rresp !== p0) stable = 1'b0;
            end
            chk({tag, " rhold"}, 64'(stable), 64'(1));
            s_rready = 1'b1; @(posedge clk); #1; s_rready = 1'b0;
            chk({tag, " rvalid_drop"}, 64'(s_rvalid), 64'(0));
            chk({tag, " rresp"}, 64'(p0), 64'(v.resp));
            chk({tag, " rdata"}, 64'(d0), 64'(v.rdata));
            chk({tag, " raddr"}, 64'(ch_raddr), 64'(v.loc));
        end else begin
            s_awaddr = v.addr; s_wdata = v.data; s_awvalid = 1'b1; s_wvalid = 1'b1; seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin @(posedge clk); #1; seen = s_awready; end
            chk({tag, " awready"}, 64'(seen), 64'(1));
            chk({tag, " wready"}, 64'(s_wready), 64'(1));
            @(posedge clk); #1; s_awvalid = 1'b0; s_wvalid = 1'b0;
            chk({tag, " aw_pulse"}, 64'({s_awready, s_wready}), 64'(0));
            seen = s_bvalid;
            for (int n = 0; n < TIMEOUT + 20 && !seen; n++) begin @(posedge clk); #1; seen = s_bvalid; end
            chk({tag, " bvalid"}, 64'(seen), 64'(1));
            p0 = s_bresp; stable = 1'b1;
            repeat (v.hold) begin
                @(posedge clk); #1;
                if (!s_bvalid || s_bresp !== p0) stable = 1'b0;
            end
            chk({tag, " bhold"}, 64'(stable), 64'(1));
            s_bready = 1'b1; @(posedge clk); #1; s_bready = 1'b0;
            chk({tag, " bvalid_drop"}, 64'(s_bvalid), 64'(0));
            chk({tag, " bresp"}, 64'(p0), 64'(v.resp));
            chk({tag, " waddr"}, 64'(ch_waddr), 64'(v.loc));
            chk({tag, " wdata"}, 64'(ch_wdata), 64'(v.data));
        end
        tot = 0; on = 0; wrong = 0;
        for (int k = 0; k < N_CHAN; k++) begin
            tot   += v.wr ? wtot[k] - ws[k] : rtot[k] - rs[k];
            wrong += v.wr ? rtot[k] - rs[k] : wtot[k] - ws[k];
            if (k == ch) on = v.wr ? wtot[k] - ws[k] : rtot[k] - rs[k];
        end
        chk({tag, " strobe_total"}, 64'(tot), 64'(v.cyc));
        chk({tag, " strobe_on_ch"}, 64'(on), 64'(v.cyc));
        chk({tag, " strobe_wrong_kind"}, 64'(wrong), 64'(0));
        noise = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t vecs [10];

    initial begin
        vec_t v;
        bit   seen, got_rd, exp_rd, stable;
        int   e_ar, e_st, e_rv;
        logic [31:0] d0;

        vecs[0] = '{0, 32'h0000_1008, 32'h0,          3, 0, 0, 2'b00, 32'hA5A5_0001, 3, 10'd2};
        vecs[1] = '{1, 32'h0000_0004, 32'h0000_1234,  1, 0, 0, 2'b00, 32'h0,         1, 10'd1};
        vecs[2] = '{0, 32'h0000_7000, 32'h0,          3, 0, 1, 2'b11, 32'h0,         0, 10'd0};
        vecs[3] = '{0, 32'h0000_2000, 32'h0,          0, 0, 0, 2'b10, 32'hDEAD_BEEF, 8, 10'd0};
        vecs[4] = '{0, 32'h0000_2010, 32'h0,          8, 0, 2, 2'b00, 32'hA5A5_0002, 8, 10'd4};
        vecs[5] = '{1, 32'h0000_5000, 32'hCAFE_0005,  2, 0, 0, 2'b11, 32'h0,         0, 10'd0};
        vecs[6] = '{1, 32'h0000_3FFC, 32'h0BAD_F00D,  0, 0, 1, 2'b10, 32'h0,         8, 10'h3FF};
        vecs[7] = '{0, 32'h0000_3004, 32'h0,          7, 1, 0, 2'b00, 32'hA5A5_0003, 7, 10'd1};
        vecs[8] = '{0, 32'h0000_0000, 32'h0,          0, 1, 0, 2'b10, 32'hDEAD_BEEF, 8, 10'd0};
        vecs[9] = '{1, 32'hFFFF_9008, 32'h5555_AAAA,  9, 0, 0, 2'b10, 32'h0,         8, 10'd2};

        s_araddr = '0; s_awaddr = '0; s_wdata = '0;
        s_arvalid = 0; s_awvalid = 0; s_wvalid = 0; s_rready = 0; s_bready = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("reset_axi", 64'({s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid}), 64'(0));
        chk("reset_ch", 64'({ch_raddr, ch_waddr, ch_rstr, ch_wstr}), 64'(0));
        chk("reset_wdata", 64'(ch_wdata), 64'(0));
        release_reset();

        // Minimum read latency: arready 1, strobe 2, rvalid 3 edges after arvalid is driven
        ack_dly = 1; s_araddr = 32'h0000_0000; s_arvalid = 1'b1; s_rready = 1'b1;
        e_ar = 0; e_st = 0; e_rv = 0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (e_ar != 0 && e == e_ar + 1) s_arvalid = 1'b0;
            if (s_arready && e_ar == 0) e_ar = e;
            if (ch_rstr != '0 && e_st == 0) e_st = e;
            if (s_rvalid && e_rv == 0) e_rv = e;
        end
        s_rready = 1'b0; s_arvalid = 1'b0;
        chk("lat_arready", 64'(e_ar), 64'(1));
        chk("lat_rstr", 64'(e_st), 64'(2));
        chk("lat_rvalid", 64'(e_rv), 64'(3));

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while the strobe is high, then while arready is high
        ack_dly = 0; s_araddr = 32'h0000_2000; s_arvalid = 1'b1; seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin @(posedge clk); #1; seen = s_arready; end
        @(posedge clk); #1; s_arvalid = 1'b0;
        seen = ch_rstr[2];
        for (int n = 0; n < 20 && !seen; n++) begin @(posedge clk); #1; seen = ch_rstr[2]; end
        chk("rst_mid strobe_up", 64'(seen), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("rst_mid outputs", 64'({ch_rstr, s_rvalid, s_arready}), 64'(0));
        release_reset();
        s_arvalid = 1'b1; seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin @(posedge clk); #1; seen = s_arready; end
        rst_n = 1'b0; #1;
        chk("rst_arready", 64'({seen, s_arready}), 64'(2));
        s_arvalid = 1'b0;
        release_reset();
        run_txn('{0, 32'h0000_1008, 32'h0, 2, 0, 0, 2'b00, 32'hA5A5_0001, 2, 10'd2}, "post_reset");

        // Both sides requesting continuously: grants alternate starting with read after reset
        rst_n = 1'b0; release_reset();
        ack_dly = 1; exp_rd = 1'b1;
        s_araddr = 32'h0000_1000; s_awaddr = 32'h0000_2000; s_wdata = 32'h7777_0001;
        s_arvalid = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            seen = 1'b0; got_rd = 1'b0;
            for (int n = 0; n < 30 && !seen; n++) begin
                @(posedge clk); #1; seen = s_arready | s_awready; got_rd = s_arready;
            end
            chk($sformatf("arb%0d grant", g), 64'({seen, got_rd}), 64'({1'b1, exp_rd}));
            exp_rd = !exp_rd;
            @(posedge clk); #1;
            if (g == 3) begin s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; end
            seen = got_rd ? s_rvalid : s_bvalid;
            for (int n = 0; n < 30 && !seen; n++) begin @(posedge clk); #1; seen = got_rd ? s_rvalid : s_bvalid; end
            if (g == 0) begin
                d0 = s_rdata; stable = s_rvalid;
                repeat (5) begin @(posedge clk); #1; if (!s_rvalid || s_rdata !== d0) stable = 1'b0; end
                chk("arb rvalid_hold", 64'(stable), 64'(1));
                chk("arb rdata", 64'(d0), 64'(32'hA5A5_0001));
            end
            s_rready = got_rd; s_bready = !got_rd;
            @(posedge clk); #1; s_rready = 1'b0; s_bready = 1'b0;
        end
        chk("arb wdata", 64'(ch_wdata), 64'(32'h7777_0001));

        // Random isolated accesses
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N_CHAN; k++) din_val[k] = $urandom;
            v = model(1'($urandom_range(0, 1)),
                      ($urandom & 32'hFFFF_8FFC) | (32'($urandom_range(0, 7)) << SEL_LSB),
                      $urandom, int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
